// File: rtl/booth_pkg.sv
// Shared types and helpers for the sequential Booth multiplier.
// The BOOTH_RADIX4_EN macro is consumed by booth_mult_seq; this package serves both builds.
package booth_pkg;

    // Controller state encoding
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    // Booth-recoded partial-product operation
    typedef enum logic [2:0] {
        NOP  = 3'd0,
        ADD1 = 3'd1,
        ADD2 = 3'd2,
        SUB1 = 3'd3,
        SUB2 = 3'd4
    } booth_op_e;

    // Iteration counter width able to hold ITER itself
    function automatic int unsigned cnt_w(input int unsigned iter);
        return $clog2(iter + 1);
    endfunction

    // Internal operand width: unsigned operands get one extra zero bit
    function automatic int unsigned oper_w(input int unsigned width, input bit signed_op);
        return signed_op ? width : width + 1;
    endfunction

    // Radix-2 recode of {Q[0], q_m1}
    function automatic booth_op_e recode_r2(input logic [1:0] pair);
        case (pair)
            2'b01:   return ADD1;
            2'b10:   return SUB1;
            default: return NOP;
        endcase
    endfunction

    // Radix-4 recode of {Q[1], Q[0], q_m1}
    function automatic booth_op_e recode_r4(input logic [2:0] trip);
        case (trip)
            3'b001, 3'b010: return ADD1;
            3'b011:         return ADD2;
            3'b100:         return SUB2;
            3'b101, 3'b110: return SUB1;
            default:        return NOP;
        endcase
    endfunction

endpackage

// File: rtl/booth_mult_seq_if.sv
// Start/done handshake and operand/product bus of the Booth multiplier.
interface booth_mult_seq_if #(
    parameter int unsigned WIDTH = 8
);
    logic                   start;
    logic [WIDTH-1:0]       multiplicand;
    logic [WIDTH-1:0]       multiplier;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;

    modport master (
        output start, multiplicand, multiplier,
        input  busy, done, product
    );

    modport slave (
        input  start, multiplicand, multiplier,
        output busy, done, product
    );
endinterface

// File: rtl/booth_ctrl.sv
// Booth multiplier controller: IDLE/RUN/DONE FSM and iteration counter.
// Emits combinational load/iterate/finish strobes for the datapath; busy/done are registered.
module booth_ctrl
    import booth_pkg::*;
#(
    parameter int unsigned ITER = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic load_c,
    output logic iterate_c,
    output logic finish_c,
    output logic busy,
    output logic done
);
    localparam int unsigned CW = cnt_w(ITER);

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    // Next-state, counter and strobe decode
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        load_c    = 1'b0;
        iterate_c = 1'b0;
        finish_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load_c  = 1'b1;
                    cnt_d   = CW'(ITER);
                    state_d = RUN;
                end
            end
            RUN: begin
                iterate_c = 1'b1;
                cnt_d     = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    finish_c = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State, counter and status registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential Booth multiplier, WIDTH x WIDTH -> 2*WIDTH, signed or unsigned.
// Define BOOTH_RADIX4_EN for modified Booth radix-4 (two bits per iteration); default is radix-2.
module booth_mult_seq
    import booth_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter bit          SIGNED = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    booth_mult_seq_if.slave   bus
);
`ifdef BOOTH_RADIX4_EN
    localparam bit RADIX4 = 1'b1;
`else
    localparam bit RADIX4 = 1'b0;
`endif

    localparam int unsigned N    = oper_w(WIDTH, SIGNED);
    localparam int unsigned NE   = RADIX4 ? N + (N % 2) : N;
    localparam int unsigned AW   = RADIX4 ? NE + 2 : NE + 1;
    localparam int unsigned ITER = RADIX4 ? NE / 2 : NE;
    localparam int unsigned PW   = 2 * WIDTH;
    localparam int unsigned SW   = AW + NE + 1;

    logic [AW-1:0] a_q, a_d;
    logic [NE-1:0] q_q, q_d;
    logic          qm1_q, qm1_d;
    logic [AW-1:0] m_q, m_d;
    logic [PW-1:0] prod_q, prod_d;

    logic          load_c, iterate_c, finish_c;
    logic          m_sign, q_sign;
    booth_op_e     op;
    logic [AW-1:0] addend, sum;
    logic [SW-1:0] shreg;

    booth_ctrl #(.ITER(ITER)) u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .start     (bus.start),
        .load_c    (load_c),
        .iterate_c (iterate_c),
        .finish_c  (finish_c),
        .busy      (bus.busy),
        .done      (bus.done)
    );

    // Operand load, Booth recode, add/sub, arithmetic shift and product capture
    always_comb begin
        a_d    = a_q;
        q_d    = q_q;
        qm1_d  = qm1_q;
        m_d    = m_q;
        prod_d = prod_q;
        op     = NOP;
        addend = '0;
        sum    = '0;
        shreg  = '0;
        m_sign = SIGNED & bus.multiplicand[WIDTH-1];
        q_sign = SIGNED & bus.multiplier[WIDTH-1];
        if (load_c) begin
            m_d   = AW'($signed({m_sign, bus.multiplicand}));
            q_d   = NE'($signed({q_sign, bus.multiplier}));
            a_d   = '0;
            qm1_d = 1'b0;
        end else if (iterate_c) begin
            op = RADIX4 ? recode_r4({q_q[1:0], qm1_q}) : recode_r2({q_q[0], qm1_q});
            case (op)
                ADD1:    addend = m_q;
                SUB1:    addend = -m_q;
                ADD2:    addend = m_q << 1;
                SUB2:    addend = -(m_q << 1);
                default: addend = '0;
            endcase
            sum   = a_q + addend;
            shreg = {sum, q_q, qm1_q};
            if (RADIX4) begin
                shreg = {{2{sum[AW-1]}}, shreg[SW-1:2]};
            end else begin
                shreg = {sum[AW-1], shreg[SW-1:1]};
            end
            a_d   = shreg[SW-1:NE+1];
            q_d   = shreg[NE:1];
            qm1_d = shreg[0];
            if (finish_c) begin
                prod_d = PW'({a_d, q_d});
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            q_q    <= '0;
            qm1_q  <= 1'b0;
            m_q    <= '0;
            prod_q <= '0;
        end else begin
            a_q    <= a_d;
            q_q    <= q_d;
            qm1_q  <= qm1_d;
            m_q    <= m_d;
            prod_q <= prod_d;
        end
    end

    assign bus.product = prod_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq: one signed and one unsigned WIDTH=8 instance.
// Honours BOOTH_RADIX4_EN for the expected latencies.
module tb_booth_mult_seq;

    localparam int unsigned W = 8;
`ifdef BOOTH_RADIX4_EN
    localparam int IT_S = 4;
    localparam int IT_U = 5;
`else
    localparam int IT_S = 8;
    localparam int IT_U = 9;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    typedef struct {
        logic [15:0] prod;
        int          cyc;
    } exp_t;

    typedef struct {
        bit          u;
        logic [7:0]  m;
        logic [7:0]  q;
        logic [15:0] e;
    } vec_t;

    exp_t        q_s[$];
    exp_t        q_u[$];
    logic [15:0] last_s = '0;
    logic [15:0] last_u = '0;

    booth_mult_seq_if #(.WIDTH(W)) bus_s ();
    booth_mult_seq_if #(.WIDTH(W)) bus_u ();

    booth_mult_seq #(.WIDTH(W), .SIGNED(1'b1)) dut_s (.clk(clk), .rst(rst), .bus(bus_s));
    booth_mult_seq #(.WIDTH(W), .SIGNED(1'b0)) dut_u (.clk(clk), .rst(rst), .bus(bus_u));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [15:0] model(input bit u, input logic [7:0] m, input logic [7:0] q);
        logic signed [15:0] sm;
        logic signed [15:0] sq;
        if (u) return 16'(m) * 16'(q);
        sm = 16'($signed(m));
        sq = 16'($signed(q));
        return 16'(sm * sq);
    endfunction

    function automatic logic busy_of(input bit u);
        return u ? bus_u.busy : bus_s.busy;
    endfunction

    function automatic logic done_of(input bit u);
        return u ? bus_u.done : bus_s.done;
    endfunction

    function automatic logic [15:0] prod_of(input bit u);
        return u ? bus_u.product : bus_s.product;
    endfunction

    function automatic string nm(input bit u, input string s);
        return {u ? "u_" : "s_", s};
    endfunction

    task automatic drive(input bit u, input logic st, input logic [7:0] m, input logic [7:0] q);
        if (u) begin
            bus_u.start = st; bus_u.multiplicand = m; bus_u.multiplier = q;
        end else begin
            bus_s.start = st; bus_s.multiplicand = m; bus_s.multiplier = q;
        end
    endtask

    task automatic push(input bit u, input logic [15:0] p, input int c);
        if (u) q_u.push_back('{prod: p, cyc: c});
        else   q_s.push_back('{prod: p, cyc: c});
    endtask

    // Scoreboard side: pop on done, otherwise product must hold its last completed value
    task automatic mon(input bit u);
        exp_t e;
        if (rst) begin
            if (u) last_u = '0; else last_s = '0;
        end else if (done_of(u)) begin
            if ((u ? q_u.size() : q_s.size()) == 0) begin
                checks++;
                failures++;
                $display("FAIL %s: actual=done_pulse required=no_pending_op (cycle %0d)",
                         nm(u, "unexpected_done"), cyc);
            end else begin
                e = u ? q_u.pop_front() : q_s.pop_front();
                check(nm(u, "product"), prod_of(u), e.prod);
                check(nm(u, "done_cycle"), cyc, e.cyc);
                if (u) last_u = e.prod; else last_s = e.prod;
            end
        end else begin
            check(nm(u, "product_hold"), prod_of(u), u ? last_u : last_s);
        end
    endtask

    always @(negedge clk) begin
        mon(1'b0);
        mon(1'b1);
    end

    task automatic start_op(input bit u, input logic [7:0] m, input logic [7:0] q,
                            input logic [15:0] e);
        @(negedge clk);
        drive(u, 1'b1, m, q);
        @(posedge clk);
        #1;
        push(u, e, cyc + (u ? IT_U : IT_S));
        drive(u, 1'b0, 8'($urandom), 8'($urandom));
        check(nm(u, "busy_after_accept"), busy_of(u), 1);
    endtask

    task automatic wait_idle(input bit u);
        int n = 0;
        while (busy_of(u) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(nm(u, "idle_within_bound"), 32'(n < 40), 1);
        check(nm(u, "pending_after_idle"), u ? q_u.size() : q_s.size(), 0);
    endtask

    task automatic run_op(input bit u, input logic [7:0] m, input logic [7:0] q,
                          input logic [15:0] e);
        start_op(u, m, q, e);
        wait_idle(u);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[11];
        int   k;
        int   n;
        int   next_acc;
        logic [7:0] m, q;

        tbl[0]  = '{1'b0, 8'd3,   8'hFC, 16'hFFF4};
        tbl[1]  = '{1'b0, 8'h80,  8'h80, 16'h4000};
        tbl[2]  = '{1'b0, 8'h80,  8'h7F, 16'hC080};
        tbl[3]  = '{1'b0, 8'h7F,  8'h7F, 16'h3F01};
        tbl[4]  = '{1'b0, 8'hFF,  8'hFF, 16'h0001};
        tbl[5]  = '{1'b0, 8'h01,  8'h80, 16'hFF80};
        tbl[6]  = '{1'b0, 8'h00,  8'h80, 16'h0000};
        tbl[7]  = '{1'b1, 8'hFF,  8'hFF, 16'hFE01};
        tbl[8]  = '{1'b1, 8'h00,  8'hC8, 16'h0000};
        tbl[9]  = '{1'b1, 8'h80,  8'h02, 16'h0100};
        tbl[10] = '{1'b1, 8'hC8,  8'h64, 16'h4E20};

        drive(1'b0, 1'b0, 8'h00, 8'h00);
        drive(1'b1, 1'b0, 8'h00, 8'h00);

        // Reset state
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            check(nm(u[0], "rst_busy"), busy_of(u[0]), 0);
            check(nm(u[0], "rst_done"), done_of(u[0]), 0);
            check(nm(u[0], "rst_product"), prod_of(u[0]), 0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < 11; i++) begin
            run_op(tbl[i].u, tbl[i].m, tbl[i].q, tbl[i].e);
        end

        // Random operands against the bench model
        for (int i = 0; i < 8; i++) begin
            for (int u = 0; u < 2; u++) begin
                m = 8'($urandom);
                q = 8'($urandom);
                run_op(u[0], m, q, model(u[0], m, q));
            end
        end

        // Start while busy is ignored; start across DONE is taken on the following edge
        run_op(1'b0, 8'd3, 8'hFC, 16'hFFF4);
        @(negedge clk);
        drive(1'b0, 1'b1, 8'd9, 8'd7);
        @(posedge clk);
        #1;
        k = cyc;
        push(1'b0, 16'd63, k + IT_S);
        drive(1'b0, 1'b0, 8'h11, 8'h22);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b1, 8'd5, 8'd5);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 8'h33, 8'h44);
        check("s_hold_mid_op", bus_s.product, 16'hFFF4);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus_s.done && n < 40);
        check("s_done_seen", 32'(n < 40), 1);
        drive(1'b0, 1'b1, 8'd2, 8'd3);
        push(1'b0, 16'd6, cyc + 2 + IT_S);
        @(posedge clk);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 8'h00, 8'h00);
        wait_idle(1'b0);

        // Asynchronous reset mid-operation aborts without a done pulse
        @(negedge clk);
        drive(1'b0, 1'b1, 8'd7, 8'd6);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 8'h00, 8'h00);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("s_abort_busy", bus_s.busy, 0);
        check("s_abort_done", bus_s.done, 0);
        check("s_abort_product", bus_s.product, 0);
        check("u_abort_product", bus_u.product, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_op(1'b0, 8'd7, 8'd6, 16'd42);

        // Start held high: accepts every ITER+2 edges
        @(negedge clk);
        next_acc = cyc + 1;
        for (int i = 0; i < 3 * (IT_U + 2); i++) begin
            if (i > 0) @(negedge clk);
            m = 8'($urandom);
            q = 8'($urandom);
            drive(1'b1, 1'b1, m, q);
            if (cyc + 1 == next_acc) begin
                push(1'b1, model(1'b1, m, q), next_acc + IT_U);
                next_acc += IT_U + 2;
            end
        end
        @(negedge clk);
        drive(1'b1, 1'b0, 8'h00, 8'h00);
        wait_idle(1'b1);

        repeat (3) @(negedge clk);
        check("s_final_pending", q_s.size(), 0);
        check("u_final_pending", q_u.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
